// File: rtl/sampler_pkg.sv
// Shared state encoding, default widths and bank-index width helper for the
// multibank sampler writer.
package sampler_pkg;

    localparam int unsigned DEF_DATA_W = 12;
    localparam int unsigned DEF_ADDR_W = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        STALL = 2'd2
    } state_t;

    function automatic int unsigned bank_w(input int unsigned n_banks);
        return (n_banks > 1) ? $clog2(n_banks) : 1;
    endfunction

endpackage

// File: rtl/sampler_multibank_writer_if.sv
// Capture, release and frame-RAM write bus of the multibank sampler writer.
interface sampler_multibank_writer_if
    import sampler_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned N_BANKS = 2,
    parameter int unsigned OVR_W   = 16,
    parameter int unsigned BANK_W  = bank_w(N_BANKS)
);

    logic              enable;
    logic              sample_tick;
    logic [DATA_W-1:0] data;
    logic              rel_valid;
    logic [BANK_W-1:0] rel_bank;

    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wr_data;
    logic [N_BANKS-1:0] wr_en;
    logic               start_round;
    logic               now_writing;
    logic               frame_ready;
    logic [BANK_W-1:0]  frame_bank;
    logic [N_BANKS-1:0] busy_mask;
    logic [OVR_W-1:0]   overrun;

    modport master (
        input  enable, sample_tick, data, rel_valid, rel_bank,
        output addr, wr_data, wr_en, start_round, now_writing,
               frame_ready, frame_bank, busy_mask, overrun
    );

    modport slave (
        output enable, sample_tick, data, rel_valid, rel_bank,
        input  addr, wr_data, wr_en, start_round, now_writing,
               frame_ready, frame_bank, busy_mask, overrun
    );

endinterface

// File: rtl/decim_accumulator.sv
// Block-average decimator: sums 2^DECIM_LOG2 ticks and flags the completing tick
// combinationally together with the truncated average.
module decim_accumulator
    import sampler_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned DECIM_LOG2 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [DATA_W-1:0] data,
    input  logic              clear,
    output logic              group_done,
    output logic [DATA_W-1:0] avg
);

    localparam int unsigned ACC_W = DATA_W + DECIM_LOG2;
    localparam int unsigned CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << DECIM_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        sum        = acc + ACC_W'(data);
        group_done = tick && (cnt == LAST);
        avg        = DATA_W'(sum >> DECIM_LOG2);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (group_done) begin
            acc <= '0;
            cnt <= '0;
        end else if (tick) begin
            acc <= sum;
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sampler_multibank_writer.sv
// Captures decimated ADC samples into ring-ordered frame banks, tracking consumer
// ownership of completed banks and counting groups dropped while stalled.
module sampler_multibank_writer
    import sampler_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned N_BANKS    = 2,
    parameter int unsigned BANK_W     = bank_w(N_BANKS),
    parameter int unsigned DECIM_LOG2 = 0,
    parameter int unsigned OVR_W      = 16
) (
    input  logic clk,
    input  logic rst,
    sampler_multibank_writer_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(N_BANKS - 1);
    localparam logic [OVR_W-1:0]  OVR_MAX   = '1;

    state_t             state, state_n;
    logic [BANK_W-1:0]  ptr, ptr_n, ptr_inc;
    logic [ADDR_W-1:0]  wptr, wptr_n;
    logic [N_BANKS-1:0] busy_rel, busy_n;
    logic [N_BANKS-1:0] wr_en_n;
    logic [ADDR_W-1:0]  addr_n;
    logic [DATA_W-1:0]  wr_data_n;
    logic               start_n;
    logic               frame_n;
    logic [BANK_W-1:0]  fbank_n;
    logic [OVR_W-1:0]   ovr_n;
    logic               acc_clear;
    logic               group_done;
    logic [DATA_W-1:0]  avg;

    // Nothing accumulates while idle or disabled, so a re-enable starts a clean group.
    assign acc_clear = !bus.enable || (state == IDLE);

    decim_accumulator #(
        .DATA_W     (DATA_W),
        .DECIM_LOG2 (DECIM_LOG2)
    ) u_decim (
        .clk        (clk),
        .rst        (rst),
        .tick       (bus.sample_tick),
        .data       (bus.data),
        .clear      (acc_clear),
        .group_done (group_done),
        .avg        (avg)
    );

    // Release applied combinationally so the FSM sees it in the same cycle.
    always_comb begin
        busy_rel = bus.busy_mask;
        if (bus.rel_valid && (32'(bus.rel_bank) < N_BANKS)) begin
            busy_rel[bus.rel_bank] = 1'b0;
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        wptr_n    = wptr;
        busy_n    = busy_rel;
        ovr_n     = bus.overrun;
        wr_en_n   = '0;
        addr_n    = bus.addr;
        wr_data_n = bus.wr_data;
        start_n   = 1'b0;
        frame_n   = 1'b0;
        fbank_n   = bus.frame_bank;
        ptr_inc   = (ptr == LAST_BANK) ? '0 : ptr + BANK_W'(1);

        if (!bus.enable) begin
            state_n = IDLE;
            wptr_n  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = busy_rel[ptr] ? STALL : FILL;
                end
                FILL: begin
                    if (group_done) begin
                        wr_en_n   = N_BANKS'(1) << ptr;
                        addr_n    = wptr;
                        wr_data_n = avg;
                        start_n   = (wptr == '0);
                        if (wptr == LAST_ADDR) begin
                            frame_n     = 1'b1;
                            fbank_n     = ptr;
                            busy_n[ptr] = 1'b1;
                            ptr_n       = ptr_inc;
                            wptr_n      = '0;
                            state_n     = busy_n[ptr_inc] ? STALL : FILL;
                        end else begin
                            wptr_n = wptr + ADDR_W'(1);
                        end
                    end
                end
                STALL: begin
                    if (group_done && (bus.overrun != OVR_MAX)) begin
                        ovr_n = bus.overrun + OVR_W'(1);
                    end
                    if (!busy_rel[ptr]) begin
                        state_n = FILL;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            ptr             <= '0;
            wptr            <= '0;
            bus.busy_mask   <= '0;
            bus.overrun     <= '0;
            bus.wr_en       <= '0;
            bus.addr        <= '0;
            bus.wr_data     <= '0;
            bus.start_round <= 1'b0;
            bus.frame_ready <= 1'b0;
            bus.frame_bank  <= '0;
            bus.now_writing <= 1'b0;
        end else begin
            state           <= state_n;
            ptr             <= ptr_n;
            wptr            <= wptr_n;
            bus.busy_mask   <= busy_n;
            bus.overrun     <= ovr_n;
            bus.wr_en       <= wr_en_n;
            bus.addr        <= addr_n;
            bus.wr_data     <= wr_data_n;
            bus.start_round <= start_n;
            bus.frame_ready <= frame_n;
            bus.frame_bank  <= fbank_n;
            bus.now_writing <= (state_n == FILL);
        end
    end

endmodule
